// File: rtl/ultrasonic_pkg.sv
// ============================================================================
// Module : ultrasonic_pkg
// Desc   : Shared types and constants for the 40 kHz ultrasonic ranging path.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

package ultrasonic_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_BLANK  = 2'd1,
        ST_LISTEN = 2'd2,
        ST_HOLD   = 2'd3
    } state_t;

    localparam int unsigned c_CLK_HZ_DEFAULT   = 50_000_000;
    localparam int unsigned c_TICK_DIV_DEFAULT = c_CLK_HZ_DEFAULT / 1_000_000;

    // Carrier timing shared with the transmit burst generator
    localparam int unsigned c_CARRIER_HZ          = 40_000;
    localparam int unsigned c_CARRIER_HALF_PERIOD = c_CLK_HZ_DEFAULT / (2 * c_CARRIER_HZ);

    // Speed of sound in m/s (equivalently mm/ms) at roughly 20 C
    localparam int unsigned c_SOUND_M_PER_S = 343;

    // Round-trip time-of-flight in us to one-way distance in mm
    function automatic int unsigned tof_us_to_mm(input int unsigned tof_us);
        return (tof_us * c_SOUND_M_PER_S) / 2000;
    endfunction

endpackage

`default_nettype wire

// File: rtl/ultrasonic_echo_conditioner.sv
// ============================================================================
// Module : ultrasonic_echo_conditioner
// Desc   : Synchronises the comparator echo, optionally glitch-filters it
//          (ULTRASONIC_ECHO_FILTER_EN) and produces a one-cycle rising-edge pulse.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module ultrasonic_echo_conditioner
    import ultrasonic_pkg::*;
#(
    parameter int unsigned FILTER_LEN = 8
)(
    input  logic clk,
    input  logic rst,
    input  logic echo_in,
    output logic echo_rise
);

    logic r_sync1;
    logic r_echo_s;
    logic r_echo_prev;
    logic w_echo_cond;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_sync1  <= 1'b0;
            r_echo_s <= 1'b0;
        end else begin
            r_sync1  <= echo_in;
            r_echo_s <= r_sync1;
        end
    end

`ifdef ULTRASONIC_ECHO_FILTER_EN
    localparam int unsigned c_FILT_W = (FILTER_LEN > 1) ? $clog2(FILTER_LEN) : 1;

    logic [c_FILT_W-1:0] r_filt_cnt;
    logic                r_filt;

    // Output flips only after FILTER_LEN consecutive samples disagree with it
    always_ff @(posedge clk) begin
        if (rst) begin
            r_filt_cnt <= '0;
            r_filt     <= 1'b0;
        end else if (r_echo_s == r_filt) begin
            r_filt_cnt <= '0;
        end else if (r_filt_cnt == c_FILT_W'(FILTER_LEN - 1)) begin
            r_filt_cnt <= '0;
            r_filt     <= r_echo_s;
        end else begin
            r_filt_cnt <= r_filt_cnt + 1'b1;
        end
    end

    assign w_echo_cond = r_filt;
`else
    logic w_unused_filter_len;
    assign w_unused_filter_len = (FILTER_LEN != 0);
    assign w_echo_cond         = r_echo_s;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            r_echo_prev <= 1'b0;
        end else begin
            r_echo_prev <= w_echo_cond;
        end
    end

    assign echo_rise = w_echo_cond & ~r_echo_prev;

endmodule

`default_nettype wire

// File: rtl/ultrasonic_echo_receiver.sv
// ============================================================================
// Module : ultrasonic_echo_receiver
// Desc   : Measures echo time-of-flight in us with blanking and timeout and
//          hands the result over valid/ready. Option: ULTRASONIC_ECHO_FILTER_EN.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module ultrasonic_echo_receiver
    import ultrasonic_pkg::*;
#(
    parameter int unsigned CLK_HZ     = c_CLK_HZ_DEFAULT,
    parameter int unsigned TICK_DIV   = CLK_HZ / 1_000_000,
    parameter int unsigned BLANK_US   = 1000,
    parameter int unsigned TIMEOUT_US = 38000,
    parameter int unsigned CNT_W      = 16,
    parameter int unsigned FILTER_LEN = 8
)(
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             echo_in,
    output logic             busy,
    output logic [CNT_W-1:0] tof_us,
    output logic             timeout,
    output logic             tof_valid,
    input  logic             tof_ready
);

    localparam int unsigned      c_PRE_W    = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [c_PRE_W-1:0] c_PRE_LAST = c_PRE_W'(TICK_DIV - 1);
    localparam logic [CNT_W-1:0] c_BLANK    = CNT_W'(BLANK_US);
    localparam logic [CNT_W-1:0] c_TIMEOUT  = CNT_W'(TIMEOUT_US);
    localparam logic [CNT_W-1:0] c_CNT_MAX  = '1;

    state_t             r_state;
    state_t             w_next_state;
    logic [c_PRE_W-1:0] r_prescaler;
    logic [CNT_W-1:0]   r_us_cnt;
    logic [CNT_W-1:0]   r_tof_us;
    logic               r_timeout;
    logic               r_tof_valid;

    logic w_echo_rise;
    logic w_counting;
    logic w_tick;
    logic w_load_echo;
    logic w_load_timeout;
    logic w_accept;

    ultrasonic_echo_conditioner #(
        .FILTER_LEN (FILTER_LEN)
    ) u_conditioner (
        .clk       (clk),
        .rst       (rst),
        .echo_in   (echo_in),
        .echo_rise (w_echo_rise)
    );

    assign w_counting = (r_state == ST_BLANK) || (r_state == ST_LISTEN);
    assign w_tick     = (r_prescaler == c_PRE_LAST);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state   = r_state;
        w_load_echo    = 1'b0;
        w_load_timeout = 1'b0;
        w_accept       = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (start) begin
                    w_next_state = ST_BLANK;
                end
            end
            ST_BLANK: begin
                if (r_us_cnt == c_BLANK) begin
                    w_next_state = ST_LISTEN;
                end
            end
            ST_LISTEN: begin
                // An echo on the timeout cycle still counts as a valid echo
                if (w_echo_rise) begin
                    w_load_echo  = 1'b1;
                    w_next_state = ST_HOLD;
                end else if (r_us_cnt == c_TIMEOUT) begin
                    w_load_timeout = 1'b1;
                    w_next_state   = ST_HOLD;
                end
            end
            ST_HOLD: begin
                if (r_tof_valid && tof_ready) begin
                    w_accept     = 1'b1;
                    w_next_state = ST_IDLE;
                end
            end
            default: w_next_state = ST_IDLE;
        endcase
    end

    // Timebase runs only while measuring; it idles at zero otherwise
    always_ff @(posedge clk) begin
        if (rst) begin
            r_prescaler <= '0;
            r_us_cnt    <= '0;
        end else if (w_counting) begin
            if (w_tick) begin
                r_prescaler <= '0;
                if (r_us_cnt != c_CNT_MAX) begin
                    r_us_cnt <= r_us_cnt + 1'b1;
                end
            end else begin
                r_prescaler <= r_prescaler + 1'b1;
            end
        end else begin
            r_prescaler <= '0;
            r_us_cnt    <= '0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_tof_us    <= '0;
            r_timeout   <= 1'b0;
            r_tof_valid <= 1'b0;
        end else if (w_load_echo) begin
            r_tof_us    <= r_us_cnt;
            r_timeout   <= 1'b0;
            r_tof_valid <= 1'b1;
        end else if (w_load_timeout) begin
            r_tof_us    <= c_TIMEOUT;
            r_timeout   <= 1'b1;
            r_tof_valid <= 1'b1;
        end else if (w_accept) begin
            r_tof_valid <= 1'b0;
        end
    end

    assign busy      = w_counting;
    assign tof_us    = r_tof_us;
    assign timeout   = r_timeout;
    assign tof_valid = r_tof_valid;

endmodule

`default_nettype wire

// File: tb/tb_ultrasonic_echo_receiver.sv
// ============================================================================
// Module : tb_ultrasonic_echo_receiver
// Desc   : Directed self-checking bench for ultrasonic_echo_receiver
//          (builds with or without ULTRASONIC_ECHO_FILTER_EN).
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_ultrasonic_echo_receiver;

    localparam int unsigned TICK_DIV   = 4;
    localparam int unsigned BLANK_US   = 5;
    localparam int unsigned TIMEOUT_US = 40;
    localparam int unsigned CNT_W      = 16;
    localparam int unsigned FILTER_LEN = 8;

    // Echo pins are driven this many cycles early so the conditioned edge lands on the intended us
`ifdef ULTRASONIC_ECHO_FILTER_EN
    localparam int LAT  = 8;
    localparam bit FILT = 1'b1;
`else
    localparam int LAT  = 0;
    localparam bit FILT = 1'b0;
`endif

    logic             clk = 1'b0;
    logic             rst;
    logic             start;
    logic             echo_in;
    logic             busy;
    logic [CNT_W-1:0] tof_us;
    logic             timeout;
    logic             tof_valid;
    logic             tof_ready;

    int vectors     = 0;
    int miscompares = 0;
    int el          = 0;

    always #5 clk = ~clk;

    ultrasonic_echo_receiver #(
        .CLK_HZ     (4_000_000),
        .TICK_DIV   (TICK_DIV),
        .BLANK_US   (BLANK_US),
        .TIMEOUT_US (TIMEOUT_US),
        .CNT_W      (CNT_W),
        .FILTER_LEN (FILTER_LEN)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .echo_in   (echo_in),
        .busy      (busy),
        .tof_us    (tof_us),
        .timeout   (timeout),
        .tof_valid (tof_valid),
        .tof_ready (tof_ready)
    );

    task automatic step();
        @(posedge clk);
        #1;
        el++;
    endtask

    task automatic run_to(input int t);
        while (el < t) step();
    endtask

    task automatic do_start();
        start = 1'b1;
        step();
        start = 1'b0;
        el = 0;
    endtask

    task automatic wait_valid(input int budget, output bit ok);
        int i = 0;
        while (tof_valid !== 1'b1 && i < budget) begin
            step();
            i++;
        end
        ok = (tof_valid === 1'b1);
    endtask

    task automatic accept();
        tof_ready = 1'b1;
        step();
        tof_ready = 1'b0;
    endtask

    task automatic settle();
        echo_in = 1'b0;
        repeat (12) step();
    endtask

    task automatic test_reset();
        rst = 1'b1;
        step();
        step();
        rst = 1'b0;
        vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL reset_busy: got %b want 0", busy); end
        vectors++; if (tof_valid !== 1'b0) begin miscompares++; $display("FAIL reset_valid: got %b want 0", tof_valid); end
        vectors++; if (tof_us !== 16'd0) begin miscompares++; $display("FAIL reset_tof: got %0d want 0", tof_us); end
        vectors++; if (timeout !== 1'b0) begin miscompares++; $display("FAIL reset_timeout: got %b want 0", timeout); end
        step();
    endtask

    task automatic test_nominal();
        bit ok;
        do_start();
        vectors++; if (busy !== 1'b1) begin miscompares++; $display("FAIL nominal_busy: got %b want 1", busy); end
        run_to(4 * 20 - 1 - LAT);
        echo_in = 1'b1;
        wait_valid(300, ok);
        vectors++; if (!ok) begin miscompares++; $display("FAIL nominal_valid: got %b want 1", tof_valid); end
        vectors++; if (tof_us !== 16'd20) begin miscompares++; $display("FAIL nominal_tof: got %0d want 20", tof_us); end
        vectors++; if (timeout !== 1'b0) begin miscompares++; $display("FAIL nominal_timeout: got %b want 0", timeout); end
        vectors++; if (el != 82) begin miscompares++; $display("FAIL nominal_latency: got %0d want 82", el); end
        accept();
        vectors++; if (tof_valid !== 1'b0 || busy !== 1'b0) begin miscompares++; $display("FAIL nominal_accept: got valid=%b busy=%b want 0 0", tof_valid, busy); end
        vectors++; if (tof_us !== 16'd20) begin miscompares++; $display("FAIL nominal_retain: got %0d want 20", tof_us); end
        settle();
    endtask

    task automatic test_blanked();
        bit ok;
        do_start();
        run_to(4 * 2 - 1 - LAT);
        echo_in = 1'b1;
        run_to(4 * 4 - 1 - LAT);
        echo_in = 1'b0;
        wait_valid(400, ok);
        vectors++; if (!ok) begin miscompares++; $display("FAIL blanked_valid: got %b want 1", tof_valid); end
        vectors++; if (timeout !== 1'b1) begin miscompares++; $display("FAIL blanked_timeout: got %b want 1", timeout); end
        vectors++; if (tof_us !== 16'd40) begin miscompares++; $display("FAIL blanked_tof: got %0d want 40", tof_us); end
        vectors++; if (el != 161) begin miscompares++; $display("FAIL blanked_latency: got %0d want 161", el); end
        accept();
        settle();
    endtask

    task automatic test_stuck();
        bit ok;
        do_start();
        run_to(4 * 3 - 1 - LAT);
        echo_in = 1'b1;
        wait_valid(400, ok);
        vectors++; if (!ok) begin miscompares++; $display("FAIL stuck_valid: got %b want 1", tof_valid); end
        vectors++; if (timeout !== 1'b1 || tof_us !== 16'd40) begin miscompares++; $display("FAIL stuck_result: got timeout=%b tof=%0d want 1 40", timeout, tof_us); end
        run_to(4 * 45 - 1);
        vectors++; if (tof_valid !== 1'b1 || tof_us !== 16'd40) begin miscompares++; $display("FAIL stuck_hold: got valid=%b tof=%0d want 1 40", tof_valid, tof_us); end
        echo_in = 1'b0;
        accept();
        settle();
    endtask

    task automatic test_backpressure();
        bit ok;
        do_start();
        run_to(4 * 20 - 1 - LAT);
        echo_in = 1'b1;
        wait_valid(300, ok);
        vectors++; if (!ok || tof_us !== 16'd20) begin miscompares++; $display("FAIL bp_first: got valid=%b tof=%0d want 1 20", tof_valid, tof_us); end
        for (int i = 0; i < 10; i++) begin
            start = (i == 2 || i == 5);
            step();
            start = 1'b0;
            vectors++;
            if (tof_valid !== 1'b1 || tof_us !== 16'd20 || timeout !== 1'b0 || busy !== 1'b0) begin
                miscompares++;
                $display("FAIL bp_stall%0d: got valid=%b tof=%0d to=%b busy=%b want 1 20 0 0", i, tof_valid, tof_us, timeout, busy);
            end
        end
        accept();
        vectors++; if (tof_valid !== 1'b0) begin miscompares++; $display("FAIL bp_accept: got %b want 0", tof_valid); end
        settle();
        vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL bp_no_queue: got busy=%b want 0", busy); end
        do_start();
        run_to(4 * 30 - 1 - LAT);
        echo_in = 1'b1;
        wait_valid(300, ok);
        vectors++; if (!ok || tof_us !== 16'd30 || timeout !== 1'b0) begin miscompares++; $display("FAIL bp_fresh: got valid=%b tof=%0d to=%b want 1 30 0", tof_valid, tof_us, timeout); end
        vectors++; if (el != 122) begin miscompares++; $display("FAIL bp_fresh_latency: got %0d want 122", el); end
        accept();
        settle();
    endtask

    task automatic test_reset_midop();
        bit ok;
        do_start();
        run_to(4 * 10 + 2);
        vectors++; if (busy !== 1'b1) begin miscompares++; $display("FAIL rmid_busy_before: got %b want 1", busy); end
        rst = 1'b1;
        step();
        rst = 1'b0;
        vectors++; if (busy !== 1'b0 || tof_valid !== 1'b0) begin miscompares++; $display("FAIL rmid_abort: got busy=%b valid=%b want 0 0", busy, tof_valid); end
        vectors++; if (tof_us !== 16'd0 || timeout !== 1'b0) begin miscompares++; $display("FAIL rmid_cleared: got tof=%0d to=%b want 0 0", tof_us, timeout); end
        step();
        do_start();
        run_to(4 * 15 - 1 - LAT);
        echo_in = 1'b1;
        wait_valid(300, ok);
        vectors++; if (!ok || tof_us !== 16'd15) begin miscompares++; $display("FAIL rmid_restart: got valid=%b tof=%0d want 1 15", tof_valid, tof_us); end
        vectors++; if (el != 62) begin miscompares++; $display("FAIL rmid_latency: got %0d want 62", el); end
        accept();
        settle();
    endtask

    task automatic test_glitch();
        bit ok;
        logic [CNT_W-1:0] exp_tof;
        exp_tof = FILT ? 16'd25 : 16'd12;
        do_start();
        run_to(4 * 12 - 1);
        echo_in = 1'b1;
        repeat (3) step();
        echo_in = 1'b0;
        run_to(4 * 25 - 1 - LAT);
        echo_in = 1'b1;
        wait_valid(300, ok);
        vectors++; if (!ok) begin miscompares++; $display("FAIL glitch_valid: got %b want 1", tof_valid); end
        vectors++; if (tof_us !== exp_tof || timeout !== 1'b0) begin miscompares++; $display("FAIL glitch_tof: got tof=%0d to=%b want %0d 0", tof_us, timeout, exp_tof); end
        accept();
        settle();
    endtask

    initial begin
        rst       = 1'b1;
        start     = 1'b0;
        echo_in   = 1'b0;
        tof_ready = 1'b0;
        test_reset();
        test_nominal();
        test_blanked();
        test_stuck();
        test_backpressure();
        test_reset_midop();
        test_glitch();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

`default_nettype wire
